// File: rtl/phy_tx_pkg.sv
// Shared definitions for the transmit-side lane scheduler: widths, idle symbol,
// scheduler state encoding and the round-robin lane picker.
package phy_tx_pkg;
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 2;
  localparam int DATA_W    = 8;
  localparam int CNT_W     = 4;
  localparam logic [DATA_W-1:0] IDLE_SYM_DEF = 8'h7C;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic              found;
    logic [LANE_W-1:0] lane;
  } rr_pick_t;

  // First requesting lane at or after ptr, wrapping; lowest offset wins.
  function automatic rr_pick_t rr_pick(input logic [NUM_LANES-1:0] req,
                                       input logic [LANE_W-1:0]    ptr);
    rr_pick_t          r;
    logic [LANE_W-1:0] idx;
    r = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      idx = ptr + LANE_W'(k);
      if (req[idx]) begin
        r.found = 1'b1;
        r.lane  = idx;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/lane_fifo2.sv
// Two-entry lane FIFO with registered full/empty flags, so the ready seen by
// the requester never depends on a same-cycle pop.
module lane_fifo2
  import phy_tx_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              not_full,
  output logic              not_empty,
  output logic              one_left
);
  logic [1:0][DATA_W-1:0] mem;
  logic                   wr_ptr, rd_ptr;
  logic [1:0]             cnt, cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt + 2'd1;
      2'b01:   cnt_nxt = cnt - 2'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem       <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      cnt       <= 2'd0;
      not_full  <= 1'b1;
      not_empty <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt       <= cnt_nxt;
      not_full  <= (cnt_nxt != 2'd2);
      not_empty <= (cnt_nxt != 2'd0);
    end
  end

  assign dout     = mem[rd_ptr];
  assign one_left = (cnt == 2'd1);
endmodule

// File: rtl/mux_sched_rr4.sv
// Four-lane round-robin byte scheduler: per-lane 2-deep FIFOs feeding one
// registered output, each grant limited to QUANTUM bytes.
module mux_sched_rr4
  import phy_tx_pkg::*;
#(
  parameter int                QUANTUM  = 4,
  parameter logic [DATA_W-1:0] IDLE_SYM = IDLE_SYM_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    in_data0,
  input  logic [DATA_W-1:0]    in_data1,
  input  logic [DATA_W-1:0]    in_data2,
  input  logic [DATA_W-1:0]    in_data3,
  input  logic [NUM_LANES-1:0] in_valid,
  output logic [NUM_LANES-1:0] in_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_LANES-1:0] grant,
  output logic                 busy
);
  logic [NUM_LANES-1:0][DATA_W-1:0] lane_din, lane_head;
  logic [NUM_LANES-1:0]             lane_push, lane_pop, lane_ne, lane_one, ne_q;

  sched_state_e      state;
  logic [LANE_W-1:0] ptr, gidx;
  logic [CNT_W-1:0]  cnt;
  logic              pop_ok, last_pop;
  rr_pick_t          pick;

  assign lane_din  = {in_data3, in_data2, in_data1, in_data0};
  assign lane_push = in_valid & in_ready;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_fifo2 u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (lane_push[i]),
      .pop       (lane_pop[i]),
      .din       (lane_din[i]),
      .dout      (lane_head[i]),
      .not_full  (in_ready[i]),
      .not_empty (lane_ne[i]),
      .one_left  (lane_one[i])
    );
  end

  // A lane becomes eligible only after its data has sat buffered a full cycle.
  assign pick     = rr_pick(lane_ne & ne_q, ptr);
  assign pop_ok   = (state == ST_SERVE) && lane_ne[gidx] && (!out_valid || out_ready);
  assign lane_pop = {NUM_LANES{pop_ok}} & grant;
  assign last_pop = pop_ok && ((cnt == CNT_W'(QUANTUM - 1)) ||
                               (lane_one[gidx] && !lane_push[gidx]));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      gidx      <= '0;
      cnt       <= '0;
      grant     <= '0;
      ne_q      <= '0;
      out_valid <= 1'b0;
      out_data  <= IDLE_SYM;
    end else begin
      ne_q <= lane_ne;
      if (pop_ok) begin
        out_data  <= lane_head[gidx];
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_data  <= IDLE_SYM;
        out_valid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (pick.found) begin
            gidx  <= pick.lane;
            grant <= NUM_LANES'(1) << pick.lane;
            cnt   <= '0;
            state <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (pop_ok) cnt <= cnt + CNT_W'(1);
          // Release on quantum, on draining the lane, or on finding it empty.
          if (last_pop || !lane_ne[gidx]) begin
            ptr   <= gidx + LANE_W'(1);
            grant <= '0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (|lane_ne) | out_valid;
endmodule

// File: tb/tb_mux_sched_rr4.sv
// Directed bench for mux_sched_rr4: reset, single byte, early release,
// round robin, backpressure and reset mid-burst.
module tb_mux_sched_rr4;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data0 = '0, in_data1 = '0, in_data2 = '0, in_data3 = '0;
  logic [3:0] in_valid = '0;
  logic [3:0] in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] grant;
  logic       busy;

  int total = 0;
  int bad = 0;
  int sent[4];
  int lim[4];
  int base[4];
  logic [7:0] got[0:31];
  int gotc[0:31];
  int n = 0;
  int cyc = 0;

  mux_sched_rr4 dut (
    .clk(clk), .reset(reset),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic drive_lanes();
    for (int i = 0; i < 4; i++) in_valid[i] = (lim[i] < 0) || (sent[i] < lim[i]);
    in_data0 = 8'(base[0] + sent[0]);
    in_data1 = 8'(base[1] + sent[1]);
    in_data2 = 8'(base[2] + sent[2]);
    in_data3 = 8'(base[3] + sent[3]);
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < 4; i++) begin
      sent[i] = 0; lim[i] = 0; base[i] = 0;
    end
    n = 0;
    drive_lanes();
  endtask

  // One clock: record the output handshake and lane pushes of the cycle just ended.
  task automatic step();
    logic [3:0] acc;
    logic       hs;
    logic [7:0] hsd;
    acc = in_valid & in_ready;
    hs  = out_valid & out_ready;
    hsd = out_data;
    @(posedge clk); #1;
    cyc++;
    if (hs && n < 32) begin
      got[n] = hsd; gotc[n] = cyc; n++;
    end
    for (int i = 0; i < 4; i++) if (acc[i]) sent[i]++;
    drive_lanes();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    clear_lanes();
    out_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
  endtask

  task automatic test_reset();
    clear_lanes();
    #2 reset = 1'b0;
    #1;
    total++; if (in_ready !== 4'b1111) begin bad++; $display("FAIL reset_in_ready got=%b exp=1111", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 8'h7C) begin bad++; $display("FAIL reset_out_data got=%h exp=7c", out_data); end
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_single();
    logic [3:0] eg [0:4];
    logic       ev [0:4];
    logic [7:0] ed [0:4];
    eg = '{4'h0, 4'h0, 4'h4, 4'h0, 4'h0};
    ev = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ed = '{8'h7C, 8'h7C, 8'h7C, 8'hA5, 8'h7C};
    clear_lanes();
    out_ready = 1'b1;
    lim[2] = 1; base[2] = 8'hA5;
    drive_lanes();
    for (int c = 0; c < 5; c++) begin
      step();
      total++; if (grant !== eg[c]) begin bad++; $display("FAIL single_grant c=%0d got=%b exp=%b", c, grant, eg[c]); end
      total++; if (out_valid !== ev[c]) begin bad++; $display("FAIL single_valid c=%0d got=%b exp=%b", c, out_valid, ev[c]); end
      total++; if (out_data !== ed[c]) begin bad++; $display("FAIL single_data c=%0d got=%h exp=%h", c, out_data, ed[c]); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b exp=0", busy); end
  endtask

  // Runs right after test_single, so ptr points at lane 3.
  task automatic test_early_release();
    logic [3:0] eg [0:9];
    logic       ev [0:9];
    logic [7:0] ed [0:9];
    eg = '{4'h0, 4'h0, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0};
    ev = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    ed = '{8'h7C, 8'h7C, 8'h7C, 8'h3A, 8'h3B, 8'h7C, 8'h00, 8'h01, 8'h02, 8'h03};
    clear_lanes();
    out_ready = 1'b1;
    lim[3] = 2; base[3] = 8'h3A;
    lim[0] = -1; base[0] = 8'h00;
    drive_lanes();
    for (int c = 0; c < 10; c++) begin
      step();
      total++; if (grant !== eg[c]) begin bad++; $display("FAIL early_grant c=%0d got=%b exp=%b", c, grant, eg[c]); end
      total++; if (out_valid !== ev[c]) begin bad++; $display("FAIL early_valid c=%0d got=%b exp=%b", c, out_valid, ev[c]); end
      total++; if (out_data !== ed[c]) begin bad++; $display("FAIL early_data c=%0d got=%h exp=%h", c, out_data, ed[c]); end
    end
  endtask

  task automatic test_round_robin();
    int guard;
    int b, ln, k, gap;
    logic [7:0] exp_d;
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin lim[i] = -1; base[i] = i * 16; end
    drive_lanes();
    guard = 0;
    while (n < 20 && guard < 200) begin step(); guard++; end
    total++; if (n < 20) begin bad++; $display("FAIL rr_timeout got=%0d exp=20", n); end
    for (int m = 0; m < n && m < 20; m++) begin
      b = m / 4; ln = b % 4; k = (b / 4) * 4 + m % 4;
      exp_d = 8'(ln * 16 + k);
      total++; if (got[m] !== exp_d) begin bad++; $display("FAIL rr_data m=%0d got=%h exp=%h", m, got[m], exp_d); end
      if (m > 0) begin
        gap = (m % 4 == 0) ? 2 : 1;
        total++; if (gotc[m] - gotc[m-1] !== gap) begin bad++; $display("FAIL rr_gap m=%0d got=%0d exp=%0d", m, gotc[m] - gotc[m-1], gap); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d;
    apply_reset();
    out_ready = 1'b0;
    lim[1] = 4; base[1] = 8'h10;
    drive_lanes();
    for (int c = 0; c < 10; c++) begin
      step();
      if (c == 1 || c == 9) begin
        total++; if (in_ready[1] !== 1'b0) begin bad++; $display("FAIL bp_ready c=%0d got=%b exp=0", c, in_ready[1]); end
      end
      if (c >= 3) begin
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid c=%0d got=%b exp=1", c, out_valid); end
        total++; if (out_data !== 8'h10) begin bad++; $display("FAIL bp_hold_data c=%0d got=%h exp=10", c, out_data); end
      end
    end
    out_ready = 1'b1;
    repeat (20) step();
    total++; if (n !== 4) begin bad++; $display("FAIL bp_count got=%0d exp=4", n); end
    for (int m = 0; m < 4 && m < n; m++) begin
      exp_d = 8'(8'h10 + m);
      total++; if (got[m] !== exp_d) begin bad++; $display("FAIL bp_data m=%0d got=%h exp=%h", m, got[m], exp_d); end
    end
  endtask

  task automatic test_reset_mid();
    logic       ev [0:5];
    logic [7:0] ed [0:5];
    ev = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    ed = '{8'h7C, 8'h7C, 8'h7C, 8'h5A, 8'h7C, 8'h7C};
    apply_reset();
    out_ready = 1'b0;
    lim[0] = -1; base[0] = 8'h00;
    lim[1] = -1; base[1] = 8'h10;
    drive_lanes();
    repeat (6) step();
    total++; if (in_ready !== 4'b1100) begin bad++; $display("FAIL mid_pre_ready got=%b exp=1100", in_ready); end
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL mid_pre_grant got=%b exp=0001", grant); end
    #3 reset = 1'b0;
    clear_lanes();
    #1;
    total++; if (in_ready !== 4'b1111) begin bad++; $display("FAIL mid_ready got=%b exp=1111", in_ready); end
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL mid_grant got=%b exp=0000", grant); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 8'h7C) begin bad++; $display("FAIL mid_data got=%h exp=7c", out_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || grant !== 4'b0000) begin bad++; $display("FAIL mid_hold got=%b/%b exp=0/0000", out_valid, grant); end
    reset = 1'b1;
    out_ready = 1'b1;
    lim[2] = 1; base[2] = 8'h5A;
    drive_lanes();
    for (int c = 0; c < 6; c++) begin
      step();
      total++; if (out_valid !== ev[c]) begin bad++; $display("FAIL mid_post_valid c=%0d got=%b exp=%b", c, out_valid, ev[c]); end
      total++; if (out_data !== ed[c]) begin bad++; $display("FAIL mid_post_data c=%0d got=%h exp=%h", c, out_data, ed[c]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_early_release();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux_sched_rr4.md
MUX_SCHED_RR4 -- requirements
Module: mux_sched_rr4

Interface
REQ-001 Parameter QUANTUM, default 4: maximum bytes one lane may send per grant (range 1..15).
REQ-002 Parameter IDLE_SYM, default 8'h7C: byte driven on out_data whenever out_valid is 0.
REQ-003 clk  input  1  single block clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_data0..in_data3  input  8 each  requester byte for lanes 0..3.
REQ-006 in_valid  input  4  bit i: in_data<i> carries a byte this cycle.
REQ-007 in_ready  output  4  bit i: lane i can accept a byte this cycle.
REQ-008 out_data  output  8  scheduled byte toward the mux datapath.
REQ-009 out_valid  output  1  out_data carries a real byte.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 grant  output  4  one-hot lane currently served; 4'b0000 when no lane is served.
REQ-012 busy  output  1  any lane FIFO non-empty or out_valid high.

Function
REQ-013 Each lane shall have a 2-entry FIFO: push when in_valid[i] and in_ready[i] are both 1.
REQ-014 in_ready[i] shall equal the registered "FIFO i not full" flag, with no combinational path from a same-cycle pop.
REQ-015 The scheduler FSM shall have exactly two states, IDLE and SERVE; after reset it is in IDLE.
REQ-016 IDLE behaviour:
- Condition: any FIFO is non-empty.
- Lane choice: the first non-empty lane searching upward from ptr, modulo 4.
- Updates: load grant with that lane, clear count, move to SERVE.
REQ-017 Pop condition: in SERVE, the granted FIFO is non-empty and (out_valid is 0 or out_ready is 1).
- On pop: its head byte loads out_data, out_valid is set, count increments.
REQ-018 Leaving SERVE:
- Trigger: a pop makes count equal QUANTUM, or a pop empties the granted FIFO, or the granted FIFO is empty with no pop possible.
- Updates: ptr becomes granted lane+1 (mod 4), grant clears, state returns to IDLE.
REQ-019 IDLE shall always last at least one cycle, giving a one-cycle arbitration bubble between grants.
REQ-020 out_valid high with out_ready low shall hold out_data and out_valid stable.
- out_valid shall clear when out_ready is 1 and no pop occurs that cycle.
REQ-021 out_data shall equal IDLE_SYM whenever out_valid is 0.
REQ-022 Latency: a byte pushed into an empty FIFO while the block is idle and other lanes are empty shall appear with out_valid=1 on the third rising edge after the push edge.
REQ-023 Bytes of one lane shall leave in push order, and no byte shall be dropped or duplicated.
REQ-024 A push and a pop on the same non-full FIFO in the same cycle shall both take effect.
REQ-025 count shall be wide enough to reach QUANTUM without wrap; ptr shall wrap from 3 to 0.

Reset
REQ-026 While reset is 0, the block shall hold these values, asynchronously:
- all FIFOs empty, so in_ready=4'b1111;
- state IDLE, ptr=0, count=0;
- grant=4'b0000, out_valid=0, out_data=IDLE_SYM, busy=0.
REQ-027 Reset asserted mid-operation shall discard all buffered and in-flight bytes without emitting any further byte.
REQ-028 The first push shall be accepted on the first rising edge after reset deasserts.

Structure
REQ-029 The IDLE/SERVE state encoding and the default IDLE_SYM constant shall live in the shared phy_tx package/header.
REQ-030 The 2-entry FIFO shall be a sub-module named lane_fifo2, instantiated four times.

Verification
REQ-031 Single byte:
- Stimulus: lane 2 pushes 8'hA5 once, out_ready=1.
- Required: out_data=8'hA5 with out_valid=1 for exactly one cycle, 3 edges after the push; grant=4'b0100 beforehand; otherwise out_data=8'h7C.
REQ-032 Round robin:
- Stimulus: all four lanes continuously valid (lane i sends i*16+n), out_ready=1.
- Required: 4 bytes from lane 0, then lanes 1, 2, 3, 0..., each burst followed by a one-cycle gap.
REQ-033 Backpressure:
- Stimulus: lane 1 pushes 8'h10..8'h13, out_ready=0 for 10 cycles, then 1.
- Required: out_data holds 8'h10 stable; in_ready[1]=0 once 2 bytes are buffered; output sequence 10,11,12,13 with nothing lost.
REQ-034 Early release:
- Stimulus: lane 3 sends 2 bytes while lane 0 is continuously valid.
- Required: lane 3 gets a 2-byte burst, the grant moves to lane 0, and ptr becomes 0.
REQ-035 Reset mid-burst:
- Stimulus: reset=0 while lane 0 is mid-burst with both FIFOs full.
- Required: outputs take the REQ-026 values immediately; after release, a new push 8'h5A is output correctly.
